// File: rtl/i2c_pkg.sv
// Shared types and widths for the single-byte I2C master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam int unsigned I2C_CNT_W  = 3;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_RW,
    ST_ACK_A,
    ST_WDATA,
    ST_RDATA,
    ST_ACK_D,
    ST_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_shift_reg.sv
// Loadable MSB-first shift register with down-counting bit counter.
// Shared by the address/RW, write-data and read-data paths.
module i2c_shift_reg
  import i2c_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [I2C_DATA_W-1:0] load_val,
  input  logic [I2C_CNT_W-1:0]  load_cnt,
  input  logic                  shift,
  input  logic                  serial_in,
  output logic                  msb,
  output logic [I2C_DATA_W-1:0] shifted_c,
  output logic [I2C_CNT_W-1:0]  cnt
);

  logic [I2C_DATA_W-1:0] q;

  assign msb       = q[I2C_DATA_W-1];
  assign shifted_c = {q[I2C_DATA_W-2:0], serial_in};

  // Load has priority over shift; counter decrements once per shifted bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_val;
      cnt <= load_cnt;
    end else if (shift) begin
      q   <= shifted_c;
      cnt <= cnt - I2C_CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address, R/W, ACK, one data byte,
// ACK/NACK, STOP. One bus bit per clk cycle.
// Optional macro I2C_ACK_CHECK_EN: a NACK in the address ACK slot aborts
// straight to STOP; when undefined, ACK values are ignored.
// Outputs are registered with the value belonging to the state being
// entered, so sda/reading line up with the state they describe.
module i2c_master
  import i2c_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  master_start,
  input  logic [I2C_ADDR_W-1:0] addr_in,
  input  logic [I2C_DATA_W-1:0] data_in,
  input  logic                  read_write_bit,
  input  logic                  sda_in,
  output logic                  sda,
  output logic                  scl,
  output logic [I2C_DATA_W-1:0] data_read,
  output logic                  reading
);

  i2c_state_t state, state_next;

  logic [I2C_DATA_W-1:0] data_r;
  logic                  rw_r;
  logic                  scl_en;

  logic                  sda_next;
  logic                  reading_next;
  logic                  scl_en_next;
  logic                  latch;
  logic                  dr_update;
  logic                  ack_abort_c;

  logic                  sr_load;
  logic [I2C_DATA_W-1:0] sr_load_val;
  logic [I2C_CNT_W-1:0]  sr_load_cnt;
  logic                  sr_shift;
  logic                  sr_msb;
  logic [I2C_DATA_W-1:0] sr_shifted_c;
  logic [I2C_CNT_W-1:0]  sr_cnt;

`ifdef I2C_ACK_CHECK_EN
  assign ack_abort_c = sda_in;
`else
  assign ack_abort_c = 1'b0;
`endif

  // Shift register holds the bit to be driven next in its MSB.
  i2c_shift_reg u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .load_val  (sr_load_val),
    .load_cnt  (sr_load_cnt),
    .shift     (sr_shift),
    .serial_in (sda_in),
    .msb       (sr_msb),
    .shifted_c (sr_shifted_c),
    .cnt       (sr_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus next-cycle output values.
  always_comb begin
    state_next   = state;
    sda_next     = 1'b1;
    reading_next = 1'b0;
    scl_en_next  = 1'b0;
    latch        = 1'b0;
    dr_update    = 1'b0;
    sr_load      = 1'b0;
    sr_load_val  = '0;
    sr_load_cnt  = '0;
    sr_shift     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (master_start) begin
          state_next = ST_START;
          sda_next   = 1'b0;
        end
      end
      ST_START: begin
        // Address MSB goes out next; remaining address bits and R/W queue up.
        latch       = 1'b1;
        sr_load     = 1'b1;
        sr_load_val = {addr_in[I2C_ADDR_W-2:0], read_write_bit, 1'b1};
        sr_load_cnt = I2C_CNT_W'(I2C_ADDR_W - 1);
        state_next  = ST_ADDR;
        sda_next    = addr_in[I2C_ADDR_W-1];
        scl_en_next = 1'b1;
      end
      ST_ADDR: begin
        sr_shift    = 1'b1;
        sda_next    = sr_msb;
        scl_en_next = 1'b1;
        if (sr_cnt == '0) state_next = ST_RW;
      end
      ST_RW: begin
        state_next  = ST_ACK_A;
        scl_en_next = 1'b1;
      end
      ST_ACK_A: begin
        if (ack_abort_c) begin
          state_next = ST_STOP;
          sda_next   = 1'b0;
        end else begin
          sr_load     = 1'b1;
          sr_load_val = {data_r[I2C_DATA_W-2:0], 1'b1};
          sr_load_cnt = I2C_CNT_W'(I2C_DATA_W - 1);
          scl_en_next = 1'b1;
          if (rw_r == I2C_WR) begin
            state_next = ST_WDATA;
            sda_next   = data_r[I2C_DATA_W-1];
          end else begin
            state_next   = ST_RDATA;
            reading_next = 1'b1;
          end
        end
      end
      ST_WDATA: begin
        sr_shift    = 1'b1;
        scl_en_next = 1'b1;
        if (sr_cnt == '0) state_next = ST_ACK_D;
        else              sda_next   = sr_msb;
      end
      ST_RDATA: begin
        sr_shift    = 1'b1;
        scl_en_next = 1'b1;
        if (sr_cnt == '0) begin
          state_next = ST_ACK_D;
          dr_update  = 1'b1;
        end else begin
          reading_next = 1'b1;
        end
      end
      ST_ACK_D: begin
        state_next = ST_STOP;
        sda_next   = 1'b0;
      end
      ST_STOP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output and transfer-parameter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sda       <= 1'b1;
      scl_en    <= 1'b0;
      reading   <= 1'b0;
      data_read <= '0;
      data_r    <= '0;
      rw_r      <= 1'b0;
    end else begin
      sda     <= sda_next;
      scl_en  <= scl_en_next;
      reading <= reading_next;
      if (latch) begin
        data_r <= data_in;
        rw_r   <= read_write_bit;
      end
      if (dr_update) data_read <= sr_shifted_c;
    end
  end

  // SCL follows ~clk while gated on, so SDA changes while SCL is low.
  assign scl = scl_en ? ~clk : 1'b1;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master with a bit-sequence reference model.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       master_start = 1'b0;
  logic [6:0] addr_in = 7'h00;
  logic [7:0] data_in = 8'h00;
  logic       read_write_bit = 1'b0;
  logic       sda_in = 1'b0;
  logic       sda;
  logic       scl;
  logic [7:0] data_read;
  logic       reading;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_dr = 8'h00;

  i2c_master dut (
    .clk            (clk),
    .reset          (reset),
    .master_start   (master_start),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .read_write_bit (read_write_bit),
    .sda_in         (sda_in),
    .sda            (sda),
    .scl            (scl),
    .data_read      (data_read),
    .reading        (reading)
  );

  always #5 clk = ~clk;

  // Runs one transfer from IDLE and checks every bus cycle against the model.
  task automatic run_xfer(input logic [6:0] a, input logic [7:0] d, input logic rw,
                          input logic [7:0] slv, input logic nack, input logic hold);
    logic exp_sda[$];
    logic abort;
    logic exp_rd;
    logic exp_scl;
    int   len;
    abort = 1'b0;
`ifdef I2C_ACK_CHECK_EN
    abort = nack;
`endif
    exp_sda.push_back(1'b0);
    for (int i = 6; i >= 0; i--) exp_sda.push_back(a[i]);
    exp_sda.push_back(rw);
    exp_sda.push_back(1'b1);
    if (!abort) begin
      for (int i = 7; i >= 0; i--) exp_sda.push_back(rw ? 1'b1 : d[i]);
      exp_sda.push_back(1'b1);
    end
    exp_sda.push_back(1'b0);
    exp_sda.push_back(1'b1);
    len = exp_sda.size();

    addr_in        = a;
    data_in        = d;
    read_write_bit = rw;
    master_start   = 1'b1;
    sda_in         = 1'b0;

    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (rw && !abort && k == 18) exp_dr = slv;
      exp_rd  = rw && !abort && (k >= 10) && (k <= 17);
      exp_scl = !((k >= 1) && (k <= len - 3));
      n_cmp++;
      if (sda !== exp_sda[k]) begin
        n_bad++;
        $display("FAIL sda cyc%0d: got %b want %b", k, sda, exp_sda[k]);
      end
      n_cmp++;
      if (reading !== exp_rd) begin
        n_bad++;
        $display("FAIL reading cyc%0d: got %b want %b", k, reading, exp_rd);
      end
      n_cmp++;
      if (scl !== exp_scl) begin
        n_bad++;
        $display("FAIL scl_hi cyc%0d: got %b want %b", k, scl, exp_scl);
      end
      n_cmp++;
      if (data_read !== exp_dr) begin
        n_bad++;
        $display("FAIL data_read cyc%0d: got %h want %h", k, data_read, exp_dr);
      end
      if (k == 1) begin
        addr_in        = 7'($urandom);
        data_in        = 8'($urandom);
        read_write_bit = 1'($urandom);
        if (!hold) master_start = 1'b0;
      end
      @(negedge clk); #1;
      n_cmp++;
      if (scl !== 1'b1) begin
        n_bad++;
        $display("FAIL scl_lo cyc%0d: got %b want 1", k, scl);
      end
      if (k == 9)                             sda_in = nack;
      else if (exp_rd)                        sda_in = slv[17-k];
      else                                    sda_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    master_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({sda, scl, reading} !== 3'b110 || data_read !== 8'h00) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got sda%b scl%b rd%b dr%h want sda1 scl1 rd0 dr00",
                 i, sda, scl, reading, data_read);
      end
    end
    @(negedge clk);
    reset        = 1'b0;
    master_start = 1'b0;
    exp_dr       = 8'h00;
    @(posedge clk); #1;
    n_cmp++;
    if ({sda, scl, reading} !== 3'b110) begin
      n_bad++;
      $display("FAIL idle_after_reset: got sda%b scl%b rd%b want 110", sda, scl, reading);
    end
  endtask

  task automatic test_write();
    run_xfer(7'h52, 8'haa, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    run_xfer(7'h70, 8'h5c, 1'b1, 8'h70, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_xfer(7'h4c, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (data_read !== 8'h70) begin
      n_bad++;
      $display("FAIL b2b_keep_dr: got %h want 70", data_read);
    end
  endtask

  task automatic test_mid_reset();
    addr_in        = 7'h15;
    data_in        = 8'hc3;
    read_write_bit = 1'b0;
    master_start   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_dr = 8'h00;
    n_cmp++;
    if ({sda, scl, reading} !== 3'b110 || data_read !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset: got sda%b scl%b rd%b dr%h want sda1 scl1 rd0 dr00",
               sda, scl, reading, data_read);
    end
    @(negedge clk);
    reset        = 1'b0;
    master_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({sda, scl, reading} !== 3'b110 || data_read !== 8'h00) begin
        n_bad++;
        $display("FAIL post_reset_idle cyc%0d: got sda%b scl%b rd%b dr%h want 1 1 0 00",
                 i, sda, scl, reading, data_read);
      end
    end
    run_xfer(7'h21, 8'h00, 1'b1, 8'h09, 1'b0, 1'b0);
    n_cmp++;
    if (data_read !== 8'h09) begin
      n_bad++;
      $display("FAIL read_after_reset: got %h want 09", data_read);
    end
  endtask

  task automatic test_ack_nack();
    run_xfer(7'($urandom), 8'($urandom), 1'b1, 8'($urandom), 1'b1, 1'b0);
    run_xfer(7'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_xfer(7'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
               1'($urandom_range(0, 3) == 0), (i < 11) ? 1'($urandom) : 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_mid_reset();
    test_ack_nack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
